// File: rtl/serial_pkg.sv
// Shared types and line-level constants for the serial word receiver.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } rx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sipo_shift.sv
// Serial-in/parallel-out shift register; MSB_FIRST picks where the first bit ends up.
module sipo_shift
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             data_in,
  output logic [WIDTH-1:0] q
);

  // LSB-first enters at the top and walks down so the first bit finishes in q[0].
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (shift_en) begin
      if (MSB_FIRST) begin
        q <= {q[WIDTH-2:0], data_in};
      end else begin
        q <= {data_in, q[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/serial_word_rx.sv
// Framed serial receiver: start bit, WIDTH data bits, stop bit, into a one-word
// valid/ready output buffer with frame-error pulse and sticky overrun flag.
module serial_word_rx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clear_err
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  rx_state_t        state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift_q;
  logic             shift_en_c;
  logic             commit_c;
  logic             buf_free_c;

  assign shift_en_c = (state == DATA);
  assign commit_c   = (state == STOP) && (data_in == STOP_BIT);
  assign buf_free_c = !word_valid || word_ready;

  sipo_shift #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_sipo (
    .clock   (clock),
    .reset   (reset),
    .shift_en(shift_en_c),
    .data_in (data_in),
    .q       (shift_q)
  );

  // Frame FSM with bit counter; busy and frame_err are registered alongside the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (data_in == START_BIT) begin
            state   <= DATA;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        DATA: begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(WIDTH - 1)) begin
            state <= STOP;
          end
        end
        STOP: begin
          // A low stop bit ends the frame here; it is never taken as a new start.
          state <= IDLE;
          busy  <= 1'b0;
          if (data_in != STOP_BIT) begin
            frame_err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output buffer and overrun; a commit into a buffer being consumed keeps valid high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (commit_c && buf_free_c) begin
        word_out   <= shift_q;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end

      if (commit_c && !buf_free_c) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
